// File: rtl/cordic_vec_sched.sv
// cordic_vec_sched: round-robin front end that shares one pipelined vectoring
// CORDIC core among N requesters. A shadow tag pipeline follows each sample
// through the core so that its result is returned to the requester it came from.
// Optional four-quadrant pre-rotation is enabled with `define CORDIC_QUADRANT_EN.

// Per-requester in-flight counter. An increment and a decrement in the same
// cycle cancel out.
module cordic_vec_cnt #(
    parameter int MAX_OUT = 4,
    parameter int CW      = 4
) (
    input  logic Clk,
    input  logic Rst,
    input  logic inc,
    input  logic dec,
    output logic full
);
    logic [CW-1:0] cnt;

    // Count handshakes up and returned results down.
    always_ff @(posedge Clk) begin
        if (Rst)                            cnt <= '0;
        else if (inc && !dec)               cnt <= cnt + 1'b1;
        else if (dec && !inc && cnt != '0)  cnt <= cnt - 1'b1;
    end

    assign full = (cnt >= CW'(MAX_OUT));
endmodule

module cordic_vec_sched #(
    parameter int N       = 4,
    parameter int LATENCY = 17,
    parameter int MAX_OUT = 4
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   en,
    output logic                   busy,
    input  logic [N-1:0]           req_valid,
    output logic [N-1:0]           req_ready,
    input  logic [N*16-1:0]        req_x,
    input  logic [N*16-1:0]        req_y,
    output logic signed [15:0]     core_x,
    output logic signed [15:0]     core_y,
    input  logic signed [15:0]     core_mag,
    input  logic signed [15:0]     core_ang,
    output logic [N-1:0]           rsp_valid,
    output logic [$clog2(N)-1:0]   rsp_id,
    output logic [15:0]            rsp_mag,
    output logic [15:0]            rsp_ang
);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [IW-1:0]       id;
`ifdef CORDIC_QUADRANT_EN
        logic signed [15:0]  off;
`endif
    } tag_t;

    state_t                state, state_nxt;
    logic [IW-1:0]         rr;
    logic [N-1:0]          full, elig;
    logic                  gok;
    logic [IW-1:0]         gid;
    logic signed [15:0]    sel_x, sel_y, iss_x, iss_y;
    tag_t                  iss_tag, tail;
    logic [LATENCY:0]      vld_pipe;
    tag_t [LATENCY:0]      tag_pipe;

`ifdef CORDIC_QUADRANT_EN
    // Two's complement negate that maps -32768 to +32767 instead of wrapping.
    function automatic logic signed [15:0] neg_sat(input logic signed [15:0] v);
        return (v == 16'sh8000) ? 16'sh7fff : -v;
    endfunction
`endif

    for (genvar i = 0; i < N; i++) begin : g_req
        assign elig[i] = req_valid[i] && !full[i];
        cordic_vec_cnt #(.MAX_OUT(MAX_OUT), .CW(4)) u_cnt (
            .Clk  (Clk),
            .Rst  (Rst),
            .inc  (req_ready[i]),
            .dec  (rsp_valid[i]),
            .full (full[i])
        );
    end

    // Round-robin pick: scan downwards so the nearest index after rr wins.
    always_comb begin
        gok = 1'b0;
        gid = '0;
        if (state == RUN) begin
            for (int k = N; k >= 1; k--) begin
                if (elig[(int'(rr) + k) % N]) begin
                    gok = 1'b1;
                    gid = IW'((int'(rr) + k) % N);
                end
            end
        end
        req_ready = gok ? (N'(1) << gid) : '0;
    end

    // Select the granted sample and, if enabled, pre-rotate it into the right half-plane.
    always_comb begin
        sel_x      = req_x[16*gid +: 16];
        sel_y      = req_y[16*gid +: 16];
        iss_x      = sel_x;
        iss_y      = sel_y;
        iss_tag    = '0;
        iss_tag.id = gid;
`ifdef CORDIC_QUADRANT_EN
        if (sel_x < 0) begin
            if (sel_y >= 0) begin
                iss_x       = sel_y;
                iss_y       = neg_sat(sel_x);
                iss_tag.off = 16'sd25736;
            end else begin
                iss_x       = neg_sat(sel_y);
                iss_y       = sel_x;
                iss_tag.off = -16'sd25736;
            end
        end
`endif
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state; drain ends once nothing is left behind the tail being retired.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (!en) state_nxt = DRAIN;
            DRAIN:   if (en) state_nxt = RUN;
                     else if (!(|vld_pipe[LATENCY-1:0])) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE) || (|vld_pipe);

    // Core input register, tag shadow pipeline and round-robin pointer.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            core_x   <= '0;
            core_y   <= '0;
            vld_pipe <= '0;
            tag_pipe <= '0;
            rr       <= IW'(N - 1);
        end else begin
            core_x   <= gok ? iss_x : '0;
            core_y   <= gok ? iss_y : '0;
            vld_pipe <= {vld_pipe[LATENCY-1:0], gok};
            tag_pipe <= {tag_pipe[LATENCY-1:0], iss_tag};
            if (gok) rr <= gid;
        end
    end

    // Result steering from the tail tag; everything zero when the tail is empty.
    always_comb begin
        tail      = tag_pipe[LATENCY];
        rsp_valid = '0;
        rsp_id    = '0;
        rsp_mag   = '0;
        rsp_ang   = '0;
        if (vld_pipe[LATENCY]) begin
            rsp_valid = N'(1) << tail.id;
            rsp_id    = tail.id;
            rsp_mag   = core_mag;
            rsp_ang   = core_ang;
`ifdef CORDIC_QUADRANT_EN
            begin
                logic signed [16:0] ang_sum;
                ang_sum = core_ang + tail.off;
                if (ang_sum > 17'sd32767)       rsp_ang = 16'h7fff;
                else if (ang_sum < -17'sd32768) rsp_ang = 16'h8000;
                else                            rsp_ang = ang_sum[15:0];
            end
`endif
        end
    end
endmodule

// File: tb/tb_cordic_vec_sched.sv
// Scoreboard bench for cordic_vec_sched with a stand-in core (fixed-latency
// delay line applying simple arithmetic) and a queue-based reference model.
module tb_cordic_vec_sched;
    localparam int N = 4, LAT = 17, MAXO = 4, IW = 2;

    logic              Clk = 1'b0, Rst, en, busy;
    logic [N-1:0]      req_valid, req_ready, rsp_valid;
    logic [N*16-1:0]   req_x, req_y;
    logic [15:0]       core_x, core_y, core_mag, core_ang, rsp_mag, rsp_ang;
    logic [IW-1:0]     rsp_id;

    cordic_vec_sched #(.N(N), .LATENCY(LAT), .MAX_OUT(MAXO)) dut (
        .Clk(Clk), .Rst(Rst), .en(en), .busy(busy),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
        .core_x(core_x), .core_y(core_y), .core_mag(core_mag), .core_ang(core_ang),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_mag(rsp_mag), .rsp_ang(rsp_ang));

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [15:0] fmag(input logic [15:0] x, input logic [15:0] y);
        return x ^ {y[7:0], y[15:8]};
    endfunction
    function automatic logic [15:0] fang(input logic [15:0] x, input logic [15:0] y);
        return x - y;
    endfunction

    // Stand-in core: output in cycle c is a function of the input from cycle c-LAT.
    logic [15:0] dx[LAT], dy[LAT];
    always @(posedge Clk) begin
        dx[0] <= core_x;
        dy[0] <= core_y;
        for (int k = 1; k < LAT; k++) begin
            dx[k] <= dx[k-1];
            dy[k] <= dy[k-1];
        end
    end
    assign core_mag = fmag(dx[LAT-1], dy[LAT-1]);
    assign core_ang = fang(dx[LAT-1], dy[LAT-1]);

    typedef struct { int due; int id; logic [15:0] mag; logic [15:0] ang; } exp_t;
    exp_t sb[$];
    exp_t pend[$];

    int checks = 0, errors = 0;
    bit armed = 0;
    int mst = 0, mrr = N - 1;
    int mout[N];
    logic [15:0] lastx = 0, lasty = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

`ifdef CORDIC_QUADRANT_EN
    function automatic logic [15:0] nsat(input logic [15:0] v);
        return (v == 16'h8000) ? 16'h7fff : -v;
    endfunction
`endif

    // Reference: decides the grant of this cycle from the rules, then advances its own state.
    task automatic model();
        int g;
        logic [15:0] sx, sy, px, py;
        int off;
        exp_t e;
        g = -1;
        if (mst == 1)
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (mrr + k) % N;
                if (g < 0 && req_valid[i] && mout[i] < MAXO) g = i;
            end
        if (armed) begin
            chk("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
            chk("busy", busy, (mst != 0 || pend.size() > 0) ? 1 : 0);
            chk("core_x", core_x, lastx);
            chk("core_y", core_y, lasty);
        end
        if (Rst) begin
            mst = 0; mrr = N - 1;
            foreach (mout[i]) mout[i] = 0;
            pend.delete(); sb.delete();
            lastx = 0; lasty = 0; armed = 1;
            return;
        end
        lastx = 0; lasty = 0;
        if (g >= 0) begin
            sx = req_x[16*g +: 16]; sy = req_y[16*g +: 16];
            px = sx; py = sy; off = 0;
`ifdef CORDIC_QUADRANT_EN
            if (sx[15]) begin
                if (!sy[15]) begin px = sy; py = nsat(sx); off = 25736; end
                else begin px = nsat(sy); py = sx; off = -25736; end
            end
`endif
            e.due = cyc + 1 + LAT; e.id = g; e.mag = fmag(px, py);
            begin
                int s;
                s = int'($signed(fang(px, py))) + off;
                if (s > 32767) s = 32767;
                if (s < -32768) s = -32768;
                e.ang = s[15:0];
            end
            sb.push_back(e); pend.push_back(e);
            mrr = g; mout[g]++; lastx = px; lasty = py;
        end
        if (pend.size() > 0 && pend[0].due == cyc) begin
            mout[pend[0].id]--;
            void'(pend.pop_front());
        end
        case (mst)
            0: if (en) mst = 1;
            1: if (!en) mst = 2;
            2: if (en) mst = 1; else if (pend.size() == 0) mst = 0;
            default: mst = 0;
        endcase
    endtask

    // Monitor: compares every presented result against the scoreboard head.
    exp_t m;
    always @(negedge Clk) if (armed) begin
        if (rsp_valid != 0) begin
            if (sb.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
            else begin
                m = sb.pop_front();
                chk("rsp_cycle", cyc, m.due);
                chk("rsp_valid", rsp_valid, 1 << m.id);
                chk("rsp_id", rsp_id, m.id);
                chk("rsp_mag", rsp_mag, m.mag);
                chk("rsp_ang", rsp_ang, m.ang);
            end
        end else begin
            chk("rsp_idle", {rsp_id, rsp_mag, rsp_ang}, 0);
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                chk("rsp_missing", rsp_valid, 1 << sb[0].id);
                void'(sb.pop_front());
            end
        end
    end

    task automatic step(input logic [N-1:0] v, input logic [N*16-1:0] x, input logic [N*16-1:0] y,
                        input logic e, input logic r);
        @(posedge Clk); #1;
        req_valid = v; req_x = x; req_y = y; en = e; Rst = r;
        #2; model();
    endtask

    task automatic rstep(input logic [N-1:0] v, input logic e, input logic r);
        logic [N*16-1:0] x, y;
        for (int i = 0; i < N; i++) begin
            x[16*i +: 16] = 16'($urandom);
            y[16*i +: 16] = 16'($urandom);
        end
        step(v, x, y, e, r);
    endtask

    initial begin
        logic [N*16-1:0] x, y;
        logic e;
        Rst = 1; en = 0; req_valid = '0; req_x = '0; req_y = '0;
        for (int k = 0; k < LAT; k++) begin dx[k] = '0; dy[k] = '0; end
        foreach (mout[i]) mout[i] = 0;

        rstep('0, 0, 1); rstep('0, 0, 1);
        repeat (3) rstep('0, 0, 0);
        // single sample from requester 0, then drain
        repeat (3) rstep('0, 1, 0);
        x = '0; y = '0; x[15:0] = 16'd1000;
        step(4'b0001, x, y, 1, 0);
        repeat (20) rstep('0, 1, 0);
        repeat (5) rstep('0, 0, 0);
        // everyone requesting for 8 cycles
        repeat (8) rstep(4'b1111, 1, 0);
        repeat (22) rstep('0, 1, 0);
        // requester 2 saturating its in-flight limit
        repeat (30) rstep(4'b0100, 1, 0);
        repeat (22) rstep('0, 1, 0);
        // three grants then enable dropped
        repeat (3) rstep(4'b1011, 1, 0);
        repeat (25) rstep('0, 0, 0);
        // reset mid-flight
        repeat (2) rstep('0, 1, 0);
        repeat (4) rstep(4'b1111, 1, 0);
        repeat (5) rstep('0, 1, 0);
        rstep('0, 0, 1);
        repeat (22) rstep('0, 0, 0);
        repeat (6) rstep(4'b1111, 1, 0);
        repeat (22) rstep('0, 1, 0);
`ifdef CORDIC_QUADRANT_EN
        x = '0; y = '0; x[15:0] = -16'sd1000;
        step(4'b0001, x, y, 1, 0);
        y[15:0] = 16'hffff;
        step(4'b0001, x, y, 1, 0);
        x[15:0] = 16'h8000; y[15:0] = 16'h0005;
        step(4'b0001, x, y, 1, 0);
        repeat (20) rstep('0, 1, 0);
`endif
        // random traffic with occasional enable toggles
        e = 1;
        repeat (400) begin
            if ($urandom_range(0, 29) == 0) e = ~e;
            rstep(N'($urandom) & N'($urandom), e, 0);
        end
        repeat (40) rstep('0, 0, 0);
        chk("sb_empty", sb.size(), 0);
        chk("final_busy", busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
